vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Generates 640x480@60 Hz VGA raster timing from the 25 MHz pixel clock.
- Sits directly upstream of every screen mapper, e.g. title, game-over and play-field mappers.
- Drives DrawX/DrawY/blank into the mapper.
- Drives hs/vs to the connector, delayed to line up with the mapper's registered ROM/palette colour path.
- Provides frame and vertical-blank strobes for game logic.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_VISIBLE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_DELAY, 2, pipeline depth applied to hs/vs only (0..7)

Ports:
vga_clk  input  1  pixel clock, all logic on rising edge
reset  input  1  synchronous, active-high
DrawX  output  10  current horizontal counter value
DrawY  output  10  current vertical counter value
blank  output  1  display-enable: 1 = visible pixel, 0 = blanking (mapper drives colour when 1)
hs  output  1  horizontal sync, active-low, delayed SYNC_DELAY clocks
vs  output  1  vertical sync, active-low, delayed SYNC_DELAY clocks
frame_start  output  1  one-clock pulse at hc==0, vc==0
vblank_start  output  1  one-clock pulse at hc==0, vc==V_VISIBLE

Behaviour:
- Totals: H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525). Both must be <=1024; 10-bit counters hc, vc.
- Reset is synchronous and active-high. On a clock edge with reset=1: hc=0, vc=0, sync delay lines filled with 1.
  - Outputs after reset: DrawX=0, DrawY=0, blank=1, hs=1, vs=1, frame_start=1, vblank_start=0.
  - Reset asserted mid-frame has the same effect on the next edge. No partial-line recovery.
- Counting (reset=0):
  - hc increments every clock.
  - At hc==H_TOTAL-1: hc wraps to 0 and vc increments.
  - At hc==H_TOTAL-1 and vc==V_TOTAL-1: both wrap to 0.
  - vc changes only on the same edge where hc wraps.
- DrawX = hc and DrawY = vc, taken directly from the counter registers. They are valid during blanking too; mappers must gate with blank.
- blank = (hc < H_VISIBLE) && (vc < V_VISIBLE). Combinational from the counter registers, so it is aligned with DrawX/DrawY in the same cycle.
- Raw horizontal sync: hs_raw = 0 iff H_VISIBLE+H_FP <= hc < H_VISIBLE+H_FP+H_SYNC (656..751).
- Raw vertical sync: vs_raw = 0 iff V_VISIBLE+V_FP <= vc < V_VISIBLE+V_FP+V_SYNC (490..491), for the full width of those lines.
- hs/vs delay:
  - hs/vs equal hs_raw/vs_raw delayed by exactly SYNC_DELAY vga_clk cycles, via a shift register.
  - SYNC_DELAY=0 gives hs/vs = hs_raw/vs_raw directly.
  - Default 2 matches the mapper: one ROM read cycle plus one colour output register.
- frame_start and vblank_start:
  - Combinational decodes of the counters, no delay.
  - Exactly one pulse per frame each: 420000 clocks apart at defaults.
- No back-pressure and no handshake. The generator free-runs and never stalls.

Test Plan:
- Reset: hold reset 3 clocks mid-frame (hc=300, vc=200), release. Expect DrawX=0, DrawY=0, blank=1, hs=1, vs=1, frame_start=1 in the first cycle. Expect DrawX=1, frame_start=0 in the next.
- Line timing, SYNC_DELAY=0:
  - blank falls when DrawX goes 639->640.
  - hs falls when DrawX becomes 656 and rises when DrawX becomes 752. Low exactly 96 clocks.
  - DrawX 799->0 with DrawY incrementing on the same edge.
- Frame timing:
  - blank stays 0 for all of lines 480..524.
  - vs low for exactly 1600 clocks, starting at DrawY=490, DrawX=0.
  - vblank_start at (0,480).
  - Wrap (799,524)->(0,0) with frame_start=1.
  - 420000 clocks between consecutive frame_start pulses.
- Sync delay, SYNC_DELAY=2: hs falls 2 clocks after DrawX becomes 656 (at DrawX=658) and rises at DrawX=754. vs edges are likewise 2 clocks late. Counters are unaffected.
- Visible-pixel count: count cycles with blank=1 over one full frame. Expect 307200. No blank=1 cycle may occur with DrawX>639 or DrawY>479.
- Reset during vsync: assert reset at DrawY=491 while vs=0. The next cycle must show vs=1 and DrawY=0. vs stays high until DrawY=490 of the following frame.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Raster timing for 640x480@60: pixel/line counters, display-enable decode,
// frame strobes, and hs/vs delayed to line up with the registered colour path.
module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SYNC_DELAY = 2
) (
    input  logic       vga_clk,
    input  logic       reset,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       frame_start,
    output logic       vblank_start
);
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic [9:0] r_hc;
    logic [9:0] r_vc;
    logic       w_hs_raw;
    logic       w_vs_raw;

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_hc <= '0;
            r_vc <= '0;
        end else if (r_hc == H_LAST) begin
            r_hc <= '0;
            r_vc <= (r_vc == V_LAST) ? 10'd0 : r_vc + 10'd1;
        end else begin
            r_hc <= r_hc + 10'd1;
        end
    end

    assign DrawX        = r_hc;
    assign DrawY        = r_vc;
    assign blank        = (r_hc < H_VIS) && (r_vc < V_VIS);
    assign frame_start  = (r_hc == 10'd0) && (r_vc == 10'd0);
    assign vblank_start = (r_hc == 10'd0) && (r_vc == V_VIS);

    // Vertical sync spans whole lines, so it depends only on the line counter.
    assign w_hs_raw = !((r_hc >= HS_BEG) && (r_hc < HS_END));
    assign w_vs_raw = !((r_vc >= VS_BEG) && (r_vc < VS_END));

    generate
        if (SYNC_DELAY == 0) begin : g_no_dly
            assign hs = w_hs_raw;
            assign vs = w_vs_raw;
        end else begin : g_dly
            logic [SYNC_DELAY-1:0] r_hs_p;
            logic [SYNC_DELAY-1:0] r_vs_p;

            // Filling with 1 keeps the connector syncs idle until real data reaches the tap.
            always_ff @(posedge vga_clk) begin
                if (reset) begin
                    r_hs_p <= '1;
                    r_vs_p <= '1;
                end else begin
                    r_hs_p <= (r_hs_p << 1) | SYNC_DELAY'(w_hs_raw);
                    r_vs_p <= (r_vs_p << 1) | SYNC_DELAY'(w_vs_raw);
                end
            end

            assign hs = r_hs_p[SYNC_DELAY-1];
            assign vs = r_vs_p[SYNC_DELAY-1];
        end
    endgenerate
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default/no delay, default/delay 2,
// small raster/delay 3) checked every cycle against an elapsed-time model.
module tb_vga_timing_gen;
    typedef struct {
        int hv; int hf; int hsw; int hb;
        int vv; int vf; int vsw; int vb;
        int d;
    } cfg_t;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic       blank;
        logic       hs;
        logic       vs;
        logic       fs;
        logic       vbs;
    } exp_t;

    localparam int S_FRAME = 32 * 17;
    localparam int S_VIS   = 20 * 10;

    logic vga_clk;
    logic reset;

    logic [9:0] x0, y0, x2, y2, xs, ys;
    logic b0, h0, v0, f0, vb0;
    logic b2, h2, v2, f2, vb2;
    logic bs, hs_s, vs_s, fs_s, vbs_s;

    cfg_t c0, c2, cs;
    exp_t q0[$];
    exp_t q2[$];
    exp_t qs[$];
    int   qt[$];

    int n_tests = 0;
    int n_fail  = 0;
    int t_cur   = 0;
    bit started = 0;

    vga_timing_gen #(.SYNC_DELAY(0)) d0 (
        .vga_clk(vga_clk), .reset(reset), .DrawX(x0), .DrawY(y0), .blank(b0),
        .hs(h0), .vs(v0), .frame_start(f0), .vblank_start(vb0));

    vga_timing_gen #(.SYNC_DELAY(2)) d2 (
        .vga_clk(vga_clk), .reset(reset), .DrawX(x2), .DrawY(y2), .blank(b2),
        .hs(h2), .vs(v2), .frame_start(f2), .vblank_start(vb2));

    vga_timing_gen #(
        .H_VISIBLE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
        .V_VISIBLE(10), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_DELAY(3)
    ) ds (
        .vga_clk(vga_clk), .reset(reset), .DrawX(xs), .DrawY(ys), .blank(bs),
        .hs(hs_s), .vs(vs_s), .frame_start(fs_s), .vblank_start(vbs_s));

    initial begin
        vga_clk = 1'b0;
        forever #20 vga_clk = ~vga_clk;
    end

    // Reference: position in the raster follows from clocks elapsed since reset.
    function automatic exp_t model(input cfg_t c, input int t);
        int ht, vt, fr, p, q, qx, qy;
        exp_t e;
        ht = c.hv + c.hf + c.hsw + c.hb;
        vt = c.vv + c.vf + c.vsw + c.vb;
        fr = ht * vt;
        p  = t % fr;
        e.x     = 10'(p % ht);
        e.y     = 10'(p / ht);
        e.blank = ((p % ht) < c.hv) && ((p / ht) < c.vv);
        e.fs    = (p == 0);
        e.vbs   = (p == c.vv * ht);
        if (t < c.d) begin
            e.hs = 1'b1;
            e.vs = 1'b1;
        end else begin
            q  = (t - c.d) % fr;
            qx = q % ht;
            qy = q / ht;
            e.hs = !(qx >= c.hv + c.hf && qx < c.hv + c.hf + c.hsw);
            e.vs = !(qy >= c.vv + c.vf && qy < c.vv + c.vf + c.vsw);
        end
        return e;
    endfunction

    task automatic chk(input string nm, input int t, input logic [9:0] act, input logic [9:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s t=%0d actual=%0d required=%0d", nm, t, act, req);
        end
    endtask

    task automatic cmp(input string id, input int t, input exp_t e, input logic [9:0] x,
                       input logic [9:0] y, input logic b, input logic h, input logic v,
                       input logic f, input logic vb);
        chk({id, ".DrawX"}, t, x, e.x);
        chk({id, ".DrawY"}, t, y, e.y);
        chk({id, ".blank"}, t, {9'd0, b}, {9'd0, e.blank});
        chk({id, ".hs"}, t, {9'd0, h}, {9'd0, e.hs});
        chk({id, ".vs"}, t, {9'd0, v}, {9'd0, e.vs});
        chk({id, ".frame_start"}, t, {9'd0, f}, {9'd0, e.fs});
        chk({id, ".vblank_start"}, t, {9'd0, vb}, {9'd0, e.vbs});
    endtask

    task automatic step(input logic r);
        @(negedge vga_clk);
        reset = r;
        @(posedge vga_clk);
        if (r) begin
            t_cur   = 0;
            started = 1'b1;
        end else begin
            t_cur++;
        end
        if (started) begin
            qt.push_back(t_cur);
            q0.push_back(model(c0, t_cur));
            q2.push_back(model(c2, t_cur));
            qs.push_back(model(cs, t_cur));
        end
    endtask

    // Monitor: pops one expectation per presented cycle, plus run-length checks.
    int   run_h0 = 0;
    int   run_vs = 0;
    int   fs_age = 0;
    int   vis    = 0;
    logic prev_h0 = 1'b1;
    logic prev_h2 = 1'b1;
    logic prev_vs = 1'b1;

    always begin
        int   tm;
        exp_t e0, e2, es;
        @(negedge vga_clk);
        if (qt.size() > 0) begin
            tm = qt.pop_front();
            e0 = q0.pop_front();
            e2 = q2.pop_front();
            es = qs.pop_front();
            cmp("d0", tm, e0, x0, y0, b0, h0, v0, f0, vb0);
            cmp("d2", tm, e2, x2, y2, b2, h2, v2, f2, vb2);
            cmp("ds", tm, es, xs, ys, bs, hs_s, vs_s, fs_s, vbs_s);

            if (tm == 0) run_h0 = 0;
            if (h0 === 1'b0) run_h0++;
            else begin
                if (prev_h0 === 1'b0 && tm != 0) chk("d0.hs_low_len", tm, 10'(run_h0), 10'd96);
                run_h0 = 0;
            end
            prev_h0 = h0;

            if (prev_h2 === 1'b1 && h2 === 1'b0) chk("d2.hs_fall_x", tm, x2, 10'd658);
            if (prev_h2 === 1'b0 && h2 === 1'b1 && tm != 0) chk("d2.hs_rise_x", tm, x2, 10'd754);
            prev_h2 = h2;

            if (tm == 0) run_vs = 0;
            if (vs_s === 1'b0) run_vs++;
            else begin
                if (prev_vs === 1'b0 && tm != 0) chk("ds.vs_low_len", tm, 10'(run_vs), 10'd64);
                run_vs = 0;
            end
            prev_vs = vs_s;

            if (tm == 0) begin
                fs_age = 0;
                vis    = 0;
            end else begin
                fs_age++;
                if (fs_s === 1'b1) begin
                    chk("ds.frame_period", tm, 10'(fs_age), 10'(S_FRAME));
                    chk("ds.visible_count", tm, 10'(vis), 10'(S_VIS));
                    fs_age = 0;
                    vis    = 0;
                end
            end
            if (bs === 1'b1) vis++;
        end
    end

    initial begin
        int n;
        reset = 1'b1;
        c0 = '{640, 16, 96, 48, 480, 10, 2, 33, 0};
        c2 = '{640, 16, 96, 48, 480, 10, 2, 33, 2};
        cs = '{20, 3, 5, 4, 10, 2, 2, 3, 3};

        repeat (3) step(1'b1);
        repeat (12000) step(1'b0);
        repeat (3) step(1'b1);
        repeat (2500) step(1'b0);

        repeat (8000) begin
            if ($urandom_range(0, 699) == 0) begin
                n = $urandom_range(1, 3);
                repeat (n) step(1'b1);
            end else begin
                step(1'b0);
            end
        end

        // Land a reset on the last vsync line of the small raster.
        for (int i = 0; i < 1200 && model(cs, t_cur).y != 10'd13; i++) step(1'b0);
        step(1'b1);
        repeat (1500) step(1'b0);

        @(negedge vga_clk);
        @(negedge vga_clk);
        #1;
        chk("sb.drain", t_cur, 10'(qt.size()), 10'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
